// File: rtl/uart_pkg.sv
// UART shared definitions: FSM encoding, oversample default, data width.
// Shared by the receive stage and the transmit rework.
package uart_pkg;

  localparam int OVS_DEFAULT = 16;
  localparam int DW          = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity check: data XOR parity bit must be 0 for even, 1 for odd.
  function automatic logic parity_err(
    input logic [DW-1:0] d,
    input logic          p,
    input logic          even
  );
    return (^d ^ p) != ~even;
  endfunction

endpackage

// File: rtl/receive_rx_sync.sv
// Two-flop synchronizer for the serial line.
// Resets to 1 (idle) so reset never looks like a start bit.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end

endmodule

// File: rtl/receive.sv
// UART receive stage: 16x oversampled frame recovery with
// receive buffer, data-ready and parity/framing/overrun status.
module receive
  import uart_pkg::*;
#(
  parameter int OVS = OVS_DEFAULT
) (
  input  logic          br,
  input  logic          rst,
  input  logic          rx,
  input  logic          pen,
  input  logic          eps,
  input  logic          rd,
  output logic [DW-1:0] rbr,
  output logic          dr,
  output logic          pe,
  output logic          fe,
  output logic          oe
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TMID = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TEND = TW'(OVS - 1);

  logic          line;
  state_t        state;
  logic [TW-1:0] tick;
  logic [2:0]    bitn;
  logic [DW-1:0] sr;
  logic          pen_q;
  logic          eps_q;
  logic          perr;

  rx_sync u_sync (
    .clk (br),
    .rst (rst),
    .d   (rx),
    .q   (line)
  );

  always_ff @(posedge br or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tick  <= '0;
      bitn  <= '0;
      sr    <= '0;
      pen_q <= 1'b0;
      eps_q <= 1'b0;
      perr  <= 1'b0;
      rbr   <= '0;
      dr    <= 1'b0;
      pe    <= 1'b0;
      fe    <= 1'b0;
      oe    <= 1'b0;
    end else begin
      // A read clears status; a commit in the same cycle overrides below.
      if (rd) begin
        dr <= 1'b0;
        pe <= 1'b0;
        fe <= 1'b0;
        oe <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (!line) begin
            state <= START;
            tick  <= '0;
          end
        end
        START: begin
          if (tick == TMID) begin
            tick <= '0;
            if (!line) begin
              state <= DATA;
              bitn  <= '0;
              pen_q <= pen;
              eps_q <= eps;
              perr  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == TEND) begin
            tick <= '0;
            sr   <= {line, sr[DW-1:1]};
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) begin
              state <= pen_q ? PARITY : STOP;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        PARITY: begin
          if (tick == TEND) begin
            tick  <= '0;
            perr  <= parity_err(sr, line, eps_q);
            state <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == TEND) begin
            tick  <= '0;
            state <= IDLE;
            if (!dr || rd) begin
              rbr <= sr;
              pe  <= perr;
              fe  <= ~line;
              dr  <= 1'b1;
            end else begin
              oe <= 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receive.sv
// Directed bench for the UART receive stage.
// Frames are driven on the pin at 16 br cycles per bit.
module tb_receive;
  import uart_pkg::*;

  logic          br;
  logic          rst;
  logic          rx;
  logic          pen;
  logic          eps;
  logic          rd;
  logic [DW-1:0] rbr;
  logic          dr;
  logic          pe;
  logic          fe;
  logic          oe;

  int checks;
  int failures;

  receive #(.OVS(16)) dut (
    .br  (br),
    .rst (rst),
    .rx  (rx),
    .pen (pen),
    .eps (eps),
    .rd  (rd),
    .rbr (rbr),
    .dr  (dr),
    .pe  (pe),
    .fe  (fe),
    .oe  (oe)
  );

  initial br = 1'b0;
  always #5 br = ~br;

  // Called at a negedge. rise = posedge count at which dr first rose.
  // rd_at > 0 makes rd high during that posedge.
  task automatic send(
    input  logic [7:0] d,
    input  logic       par_en,
    input  logic       par,
    input  logic       stop,
    input  int         rd_at,
    output int         rise
  );
    logic [10:0] bits;
    int nb;
    int n;
    logic prev;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (par_en) begin
      bits[9] = par;
      bits[10] = stop;
      nb = 11;
    end else begin
      bits[9] = stop;
      nb = 10;
    end
    rise = -1;
    n = 0;
    prev = dr;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      for (int k = 0; k < 16; k++) begin
        @(negedge br);
        n++;
        if (rise < 0 && dr && !prev) rise = n;
        prev = dr;
        rd = (rd_at > 0 && n == rd_at - 1);
      end
    end
    rx = 1'b1;
    rd = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge br);
    rd = 1'b0;
    @(negedge br);
  endtask

  task automatic test_reset();
    checks++;
    if (rbr !== 8'h00 || dr !== 1'b0 || pe !== 1'b0 ||
        fe !== 1'b0 || oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rbr=%h dr=%b pe=%b fe=%b oe=%b want 00 0 0 0 0",
               rbr, dr, pe, fe, oe);
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got %0d want %0d", dut.state, IDLE);
    end
  endtask

  task automatic test_basic();
    int rise;
    pen = 1'b0;
    send(8'hA5, 1'b0, 1'b0, 1'b1, 0, rise);
    checks++;
    if (rise !== 155) begin
      failures++;
      $display("FAIL basic_dr_cycle got %0d want 155", rise);
    end
    checks++;
    if (rbr !== 8'hA5 || dr !== 1'b1) begin
      failures++;
      $display("FAIL basic_data got rbr=%h dr=%b want a5 1", rbr, dr);
    end
    checks++;
    if (pe !== 1'b0 || fe !== 1'b0 || oe !== 1'b0) begin
      failures++;
      $display("FAIL basic_status got pe=%b fe=%b oe=%b want 0 0 0", pe, fe, oe);
    end
    pulse_rd();
    checks++;
    if (dr !== 1'b0) begin
      failures++;
      $display("FAIL basic_rd got dr=%b want 0", dr);
    end
  endtask

  task automatic test_parity();
    int rise;
    pen = 1'b1;
    eps = 1'b1;
    send(8'h3C, 1'b1, 1'b0, 1'b1, 0, rise);
    checks++;
    if (rise !== 171) begin
      failures++;
      $display("FAIL parity_dr_cycle got %0d want 171", rise);
    end
    checks++;
    if (pe !== 1'b0 || rbr !== 8'h3C || dr !== 1'b1) begin
      failures++;
      $display("FAIL parity_good got pe=%b rbr=%h dr=%b want 0 3c 1", pe, rbr, dr);
    end
    pulse_rd();
    // Flip pen mid-frame: the value at the start bit must be held.
    fork
      send(8'h3C, 1'b1, 1'b1, 1'b1, 0, rise);
      begin
        repeat (60) @(negedge br);
        pen = 1'b0;
        eps = 1'b0;
      end
    join
    checks++;
    if (pe !== 1'b1 || rbr !== 8'h3C || dr !== 1'b1) begin
      failures++;
      $display("FAIL parity_bad got pe=%b rbr=%h dr=%b want 1 3c 1", pe, rbr, dr);
    end
    pulse_rd();
    checks++;
    if (pe !== 1'b0 || dr !== 1'b0) begin
      failures++;
      $display("FAIL parity_rd_clear got pe=%b dr=%b want 0 0", pe, dr);
    end
  endtask

  task automatic test_framing();
    int rise;
    pen = 1'b0;
    send(8'h81, 1'b0, 1'b0, 1'b0, 0, rise);
    repeat (24) @(negedge br);
    checks++;
    if (fe !== 1'b1 || dr !== 1'b1 || rbr !== 8'h81) begin
      failures++;
      $display("FAIL framing_err got fe=%b dr=%b rbr=%h want 1 1 81", fe, dr, rbr);
    end
    pulse_rd();
    send(8'h42, 1'b0, 1'b0, 1'b1, 0, rise);
    checks++;
    if (fe !== 1'b0 || dr !== 1'b1 || rbr !== 8'h42) begin
      failures++;
      $display("FAIL framing_clear got fe=%b dr=%b rbr=%h want 0 1 42", fe, dr, rbr);
    end
    pulse_rd();
  endtask

  task automatic test_back_to_back();
    int rise;
    pen = 1'b0;
    send(8'h11, 1'b0, 1'b0, 1'b1, 0, rise);
    send(8'h22, 1'b0, 1'b0, 1'b1, 0, rise);
    checks++;
    if (rbr !== 8'h11 || oe !== 1'b1 || dr !== 1'b1) begin
      failures++;
      $display("FAIL overrun got rbr=%h oe=%b dr=%b want 11 1 1", rbr, oe, dr);
    end
    send(8'h33, 1'b0, 1'b0, 1'b1, 155, rise);
    checks++;
    if (rbr !== 8'h33 || dr !== 1'b1) begin
      failures++;
      $display("FAIL rd_at_commit got rbr=%h dr=%b want 33 1", rbr, dr);
    end
    checks++;
    if (pe !== 1'b0 || fe !== 1'b0) begin
      failures++;
      $display("FAIL rd_at_commit_status got pe=%b fe=%b want 0 0", pe, fe);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rise;
    rx = 1'b0;
    repeat (16) @(negedge br);
    rx = 1'b1;
    repeat (40) @(negedge br);
    checks++;
    if (dut.state !== DATA) begin
      failures++;
      $display("FAIL mid_frame_state got %0d want %0d", dut.state, DATA);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rbr !== 8'h00 || dr !== 1'b0 || pe !== 1'b0 ||
        fe !== 1'b0 || oe !== 1'b0) begin
      failures++;
      $display("FAIL mid_frame_reset got rbr=%h dr=%b pe=%b fe=%b oe=%b want 00 0 0 0 0",
               rbr, dr, pe, fe, oe);
    end
    repeat (2) @(negedge br);
    rst = 1'b0;
    repeat (4) @(negedge br);
    send(8'h5A, 1'b0, 1'b0, 1'b1, 0, rise);
    checks++;
    if (rbr !== 8'h5A || dr !== 1'b1 || oe !== 1'b0) begin
      failures++;
      $display("FAIL after_reset got rbr=%h dr=%b oe=%b want 5a 1 0", rbr, dr, oe);
    end
    pulse_rd();
    checks++;
    if (dr !== 1'b0 || oe !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_rd got dr=%b oe=%b want 0 0", dr, oe);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (4) @(negedge br);
    rx = 1'b1;
    repeat (30) @(negedge br);
    checks++;
    if (dr !== 1'b0) begin
      failures++;
      $display("FAIL glitch_dr got %b want 0", dr);
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL glitch_state got %0d want %0d", dut.state, IDLE);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    rx = 1'b1;
    pen = 1'b0;
    eps = 1'b0;
    rd = 1'b0;
    repeat (3) @(negedge br);
    test_reset();
    rst = 1'b0;
    repeat (4) @(negedge br);
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
